// File: rtl/fact_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fact_pkg                                                         |
// | Desc     : Shared controller state codes and counter constants for the      |
// |            factorisation game.                                              |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package fact_pkg;

  typedef enum logic [3:0] {
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_DRAW     = 4'b0110,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } fact_state_e;

  localparam int unsigned CODE_BLANK = 0;

  // Any of these states ends the round and wipes the entry/question context.
  function automatic logic is_round_end(input logic [3:0] st);
    return (st == ST_DRAW) || (st == ST_GOOD) || (st == ST_OUCH) ||
           (st == ST_WIN)  || (st == ST_LOSE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : btn_edge                                                         |
// | Desc     : Registered rising-edge detector; a held level yields one pulse.  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module btn_edge #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_btn_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_btn_q <= '0;
    end else begin
      r_btn_q <= i_btn;
    end
  end

  assign o_rise = i_btn & ~r_btn_q;

endmodule
`default_nettype wire

// File: rtl/answer_entry_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : answer_entry_ctrl                                                |
// | Desc     : Answer-entry counters, judge handshake and question hold with    |
// |            7-seg digit output for the factorisation game.                   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module answer_entry_ctrl
  import fact_pkg::*;
#(
  parameter int NUM_SLOTS  = 3,
  parameter int DIGIT_W    = 4,
  parameter int MAX_CODE   = 9,
  parameter int QUESTION_W = 26
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [3:0]                       STATE,
  input  logic [NUM_SLOTS-1:0]             SEL,
  input  logic                             CLR,
  input  logic                             DEC,
  input  logic [QUESTION_W-1:0]            QUESTION,
  input  logic                             QUESTION_VALID,
  input  logic                             ANS_ACK,
  output logic [NUM_SLOTS*DIGIT_W-1:0]     ANSWER,
  output logic                             ANS_VALID,
  output logic                             QUE_OK,
  output logic [2*NUM_SLOTS*DIGIT_W-1:0]   SEG
);

  localparam int c_ANS_W = NUM_SLOTS * DIGIT_W;
  localparam int c_SEG_W = 2 * c_ANS_W;
  localparam int c_BTN_W = NUM_SLOTS + 2;
  localparam logic [DIGIT_W-1:0] c_BLANK = DIGIT_W'(CODE_BLANK);
  localparam logic [DIGIT_W-1:0] c_MAX   = DIGIT_W'(MAX_CODE);
  localparam logic [DIGIT_W-1:0] c_FIRST = DIGIT_W'(1);

  logic [c_BTN_W-1:0]   w_btn;
  logic [c_BTN_W-1:0]   w_rise;
  logic                 w_dec_evt;
  logic                 w_clr_evt;
  logic [NUM_SLOTS-1:0] w_sel_evt;
  logic                 w_entry_active;
  logic                 w_round_end;
  logic                 w_unused_question_lo;

  logic [DIGIT_W-1:0]   w_count [NUM_SLOTS];
  logic [c_ANS_W-1:0]   w_count_flat;
  logic [c_SEG_W-1:0]   w_seg_input;
  logic [c_SEG_W-1:0]   w_seg_question;

  logic [13:0]          r_question;
  logic                 r_que_ok;
  logic                 r_ans_valid;
  logic [c_ANS_W-1:0]   r_answer;
  logic [c_SEG_W-1:0]   r_seg;

  assign w_btn = {DEC, CLR, SEL};

  btn_edge #(
    .W (c_BTN_W)
  ) u_btn_edge (
    .CLK    (CLK),
    .RST    (RST),
    .i_btn  (w_btn),
    .o_rise (w_rise)
  );

  assign w_dec_evt      = w_rise[c_BTN_W-1];
  assign w_clr_evt      = w_rise[NUM_SLOTS];
  assign w_sel_evt      = w_rise[NUM_SLOTS-1:0];
  assign w_entry_active = (STATE == ST_INPUT) && !r_ans_valid;
  assign w_round_end    = is_round_end(STATE);

  // Only the top 14 bits of the DB word carry {diff, q}.
  assign w_unused_question_lo = ^QUESTION[QUESTION_W-15:0];

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [DIGIT_W-1:0] r_cnt;
      logic [DIGIT_W-1:0] w_cnt_step;

      // Blank steps to 1 through the plain increment; MAX wraps to 1, never to blank.
      assign w_cnt_step = (r_cnt == c_MAX) ? c_FIRST : (r_cnt + c_FIRST);

      always_ff @(posedge CLK) begin
        if (RST || w_round_end) begin
          r_cnt <= c_BLANK;
        end else if (w_entry_active && !w_dec_evt) begin
          if (w_clr_evt) begin
            r_cnt <= c_BLANK;
          end else if (w_sel_evt[gi]) begin
            r_cnt <= w_cnt_step;
          end
        end
      end

      assign w_count[gi]                                = r_cnt;
      assign w_count_flat[gi*DIGIT_W +: DIGIT_W]        = r_cnt;
      assign w_seg_input[2*gi*DIGIT_W +: 2*DIGIT_W]     = {r_cnt, r_cnt};
    end
  endgenerate

  always_comb begin
    w_seg_question                                  = '0;
    w_seg_question[0*DIGIT_W +: DIGIT_W]            = DIGIT_W'(r_question[3:0]);
    w_seg_question[1*DIGIT_W +: DIGIT_W]            = DIGIT_W'(r_question[7:4]);
    w_seg_question[2*DIGIT_W +: DIGIT_W]            = DIGIT_W'(r_question[11:8]);
    w_seg_question[(2*NUM_SLOTS-1)*DIGIT_W +: DIGIT_W] = DIGIT_W'(r_question[13:12]);
  end

  always_ff @(posedge CLK) begin
    if (RST || w_round_end) begin
      r_question  <= '0;
      r_que_ok    <= 1'b0;
      r_ans_valid <= 1'b0;
      r_answer    <= '0;
      r_seg       <= '0;
    end else begin
      // ANS_VALID gates entry, so a DEC in the drop cycle never re-arms.
      if (r_ans_valid && ANS_ACK) begin
        r_ans_valid <= 1'b0;
      end else if (w_entry_active && w_dec_evt) begin
        r_answer    <= w_count_flat;
        r_ans_valid <= 1'b1;
      end

      if (QUESTION_VALID && !r_que_ok) begin
        r_question <= QUESTION[QUESTION_W-1 -: 14];
        r_que_ok   <= 1'b1;
      end

      if (STATE == ST_INPUT) begin
        r_seg <= w_seg_input;
      end else if (STATE == ST_QUESTION) begin
        r_seg <= w_seg_question;
      end
    end
  end

  assign ANSWER    = r_answer;
  assign ANS_VALID = r_ans_valid;
  assign QUE_OK    = r_que_ok;
  assign SEG       = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_answer_entry_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_answer_entry_ctrl                                             |
// | Desc     : Directed self-checking bench for answer_entry_ctrl (N=3).        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_answer_entry_ctrl;
  import fact_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  state;
  logic [2:0]  sel;
  logic        clr;
  logic        dec;
  logic [25:0] question;
  logic        question_valid;
  logic        ans_ack;
  logic [11:0] answer;
  logic        ans_valid;
  logic        que_ok;
  logic [23:0] seg;

  int n_tests = 0;
  int n_fail  = 0;

  answer_entry_ctrl #(
    .NUM_SLOTS  (3),
    .DIGIT_W    (4),
    .MAX_CODE   (9),
    .QUESTION_W (26)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .STATE          (state),
    .SEL            (sel),
    .CLR            (clr),
    .DEC            (dec),
    .QUESTION       (question),
    .QUESTION_VALID (question_valid),
    .ANS_ACK        (ans_ack),
    .ANSWER         (answer),
    .ANS_VALID      (ans_valid),
    .QUE_OK         (que_ok),
    .SEG            (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; state = ST_INPUT; sel = '0; clr = 1'b0; dec = 1'b0;
    question = '0; question_valid = 1'b0; ans_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_answer", answer, 0);
    check("reset_ans_valid", ans_valid, 0);
    check("reset_que_ok", que_ok, 0);
    check("reset_seg", seg, 0);

    // 1: held button counts once, then wrap 9 -> 1
    sel = 3'b001;
    repeat (5) tick();
    check("hold_one_event", seg, 24'h000011);
    sel = 3'b000; tick();
    for (int i = 0; i < 8; i++) begin
      sel = 3'b001; tick();
      sel = 3'b000; tick();
    end
    check("count_reach_max", seg, 24'h000099);
    sel = 3'b001; tick();
    sel = 3'b000; tick();
    check("wrap_to_one", seg, 24'h000011);

    // 2: clear, then simultaneous slot presses
    clr = 1'b1; tick();
    clr = 1'b0; tick();
    check("clear_all", seg, 24'h000000);
    sel = 3'b101; tick();
    check("seg_lags_count", seg, 24'h000000);
    sel = 3'b000; tick();
    check("simul_sel", seg, 24'h110011);

    // 3: build {3,2,1}, decide and hold the handshake
    for (int i = 0; i < 2; i++) begin
      sel = 3'b110; tick();
      sel = 3'b000; tick();
    end
    check("counts_321", seg, 24'h332211);
    dec = 1'b1; tick();
    dec = 1'b0;
    check("dec_answer", answer, 12'h321);
    check("dec_valid", ans_valid, 1);
    for (int i = 0; i < 10; i++) begin
      sel = 3'b111; tick();
      sel = 3'b000; tick();
    end
    check("answer_stable", answer, 12'h321);
    check("valid_held", ans_valid, 1);
    check("sel_ignored", seg, 24'h332211);
    ans_ack = 1'b1; dec = 1'b1; tick();
    ans_ack = 1'b0;
    check("ack_drop", ans_valid, 0);
    tick();
    dec = 1'b0;
    check("dec_in_drop_ignored", ans_valid, 0);

    // 4: question latch and display
    question = {14'h2123, 12'h000}; question_valid = 1'b1; tick();
    question_valid = 1'b0;
    check("que_ok_set", que_ok, 1);
    state = ST_QUESTION; tick();
    check("seg_question", seg, 24'h200123);
    question = {14'h3fff, 12'habc}; question_valid = 1'b1; tick();
    question_valid = 1'b0; tick();
    check("second_strobe_seg", seg, 24'h200123);
    check("second_strobe_ok", que_ok, 1);

    // 5: DEC beats CLR, then round end
    state = ST_INPUT;
    clr = 1'b1; tick();
    clr = 1'b0; tick();
    sel = 3'b111; tick();
    sel = 3'b000; tick();
    check("counts_111", seg, 24'h111111);
    dec = 1'b1; clr = 1'b1; tick();
    dec = 1'b0; clr = 1'b0;
    check("dec_over_clr_answer", answer, 12'h111);
    tick();
    check("dec_over_clr_counts", seg, 24'h111111);
    state = ST_WIN; tick();
    check("win_seg", seg, 0);
    check("win_que_ok", que_ok, 0);
    check("win_ans_valid", ans_valid, 0);
    check("win_answer", answer, 0);
    state = ST_INPUT; tick(); tick();
    check("win_counts", seg, 0);

    // 6: reset in the middle of a handshake
    question = {14'h1456, 12'h000}; question_valid = 1'b1; tick();
    question_valid = 1'b0;
    sel = 3'b001; tick();
    sel = 3'b000; tick();
    dec = 1'b1; tick();
    dec = 1'b0;
    check("pre_rst_valid", ans_valid, 1);
    check("pre_rst_answer", answer, 12'h001);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_ans_valid", ans_valid, 0);
    check("rst_answer", answer, 0);
    check("rst_que_ok", que_ok, 0);
    check("rst_seg", seg, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
